// File: rtl/if_prefetch_queue_pkg.sv
// if_prefetch_queue_pkg: shared fetch constants, default widths and FSM state encoding
package if_prefetch_queue_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int PC_STEP = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    typedef enum logic {FETCH, DROP} state_t;
endpackage

// File: rtl/if_prefetch_queue_if.sv
// if_prefetch_queue_if: decode, jump and instruction-memory signals of the fetch queue
interface if_prefetch_queue_if
    import if_prefetch_queue_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              le;
    logic              j;
    logic [ADDR_W-1:0] ta;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_ack;
    logic [DATA_W-1:0] im_data;
    logic              out_valid;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] instruction;
    modport master (
        input  le, j, ta, im_ack, im_data,
        output im_req, im_addr, out_valid, address, instruction
    );
    modport slave (
        output le, j, ta, im_ack, im_data,
        input  im_req, im_addr, out_valid, address, instruction
    );
endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// if_prefetch_queue_fifo: circular buffer of {address, instruction} with clear and combinational head
module if_prefetch_queue_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 40,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: fetch PC, single-outstanding memory requests and flushable instruction queue
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic clk,
    input logic rst_n,
    if_prefetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [CW-1:0] count, cnt_nxt;
    logic [ADDR_W+DATA_W-1:0] head;
    logic busy, push, pop, issue;
    // busy: a request stays outstanding past this edge, so it must hold req/addr
    always_comb begin
        busy = bus.im_req && !bus.im_ack;
        push = state == FETCH && bus.im_req && bus.im_ack && !bus.j;
        pop = bus.le && bus.out_valid && !bus.j;
        cnt_nxt = bus.j ? '0 : count + CW'(push) - CW'(pop);
        pc_nxt = bus.j ? bus.ta : push ? pc + ADDR_W'(PC_STEP) : pc;
        state_nxt = busy && (bus.j || state == DROP) ? DROP : FETCH;
        issue = !busy && cnt_nxt < CW'(DEPTH);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc <= RESET_PC;
            bus.im_req <= 1'b0;
            bus.im_addr <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            bus.im_req <= busy || issue;
            if (issue) bus.im_addr <= pc_nxt;
        end
    end
    if_prefetch_queue_fifo #(.DEPTH(DEPTH), .W(ADDR_W + DATA_W)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .clear(bus.j),
        .push(push),
        .pop(pop),
        .din({pc, bus.im_data}),
        .head(head),
        .count(count)
    );
    assign bus.out_valid = count != '0;
    assign bus.address = bus.out_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign bus.instruction = bus.out_valid ? head[DATA_W-1:0] : DATA_W'(NOP_INSTR);
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed scenarios against a variable-latency instruction memory model
module tb_if_prefetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int failures = 0;
    int lat = 1;
    int wait_cnt = 0;
    int ack_cnt = 0;
    always #5 clk = ~clk;
    if_prefetch_queue_if #(.ADDR_W(8), .DATA_W(32)) bus ();
    if_prefetch_queue #(.DEPTH(4), .ADDR_W(8), .DATA_W(32), .RESET_PC(8'h00)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    function automatic logic [31:0] instr_of(input logic [7:0] a);
        return {16'hC0DE, 8'h00, a};
    endfunction
    always @(negedge clk) begin
        if (bus.im_req && wait_cnt == lat - 1) begin
            bus.im_ack <= 1'b1;
            bus.im_data <= instr_of(bus.im_addr);
            wait_cnt <= 0;
            ack_cnt <= ack_cnt + 1;
        end else begin
            bus.im_ack <= 1'b0;
            bus.im_data <= 32'hDEAD_BEEF;
            wait_cnt <= bus.im_req ? wait_cnt + 1 : 0;
        end
    end
    task automatic do_reset(input int l);
        lat = l;
        bus.le = 1'b0;
        bus.j = 1'b0;
        bus.ta = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic wait_valid(input string name);
        for (int k = 0; k < 40 && !bus.out_valid; k++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout out_valid=%b required=1", name, bus.out_valid);
        end
    endtask
    task automatic test_reset();
        bus.le = 1'b0;
        bus.j = 1'b0;
        bus.ta = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.im_req, bus.im_addr, bus.out_valid, bus.address, bus.instruction} !== 50'h0) begin
            failures++;
            $display("FAIL reset req=%b addr=%h valid=%b address=%h instr=%h required all zero",
                     bus.im_req, bus.im_addr, bus.out_valid, bus.address, bus.instruction);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic test_stream();
        do_reset(1);
        bus.le = 1'b1;
        wait_valid("stream");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.address !== 8'(4 * i) || bus.instruction !== instr_of(8'(4 * i))) begin
                failures++;
                $display("FAIL stream[%0d] valid=%b address=%h instr=%h required valid=1 address=%h instr=%h",
                         i, bus.out_valid, bus.address, bus.instruction, 8'(4 * i), instr_of(8'(4 * i)));
            end
            @(negedge clk);
            #1;
        end
    endtask
    task automatic test_stall_fill();
        int base;
        do_reset(1);
        base = ack_cnt;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (ack_cnt - base !== 4 || bus.im_req !== 1'b0) begin
            failures++;
            $display("FAIL fill_full acks=%0d req=%b required acks=4 req=0", ack_cnt - base, bus.im_req);
        end
        bus.le = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.address !== 8'(4 * i) || bus.instruction !== instr_of(8'(4 * i))) begin
                failures++;
                $display("FAIL drain[%0d] valid=%b address=%h instr=%h required valid=1 address=%h instr=%h",
                         i, bus.out_valid, bus.address, bus.instruction, 8'(4 * i), instr_of(8'(4 * i)));
            end
            @(negedge clk);
            #1;
        end
    endtask
    task automatic test_flush_drop();
        do_reset(3);
        for (int k = 0; k < 10 && !bus.im_req; k++) begin
            @(negedge clk);
            #1;
        end
        bus.j = 1'b1;
        bus.ta = 8'h40;
        @(negedge clk);
        #1;
        bus.j = 1'b0;
        checks++;
        if (bus.im_req !== 1'b1 || bus.im_addr !== 8'h00 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_hold req=%b addr=%h valid=%b required req=1 addr=00 valid=0",
                     bus.im_req, bus.im_addr, bus.out_valid);
        end
        wait_valid("drop");
        checks++;
        if (bus.address !== 8'h40 || bus.instruction !== instr_of(8'h40)) begin
            failures++;
            $display("FAIL drop_target address=%h instr=%h required address=40 instr=%h",
                     bus.address, bus.instruction, instr_of(8'h40));
        end
    endtask
    task automatic test_flush_ack();
        do_reset(3);
        for (int k = 0; k < 10 && !bus.im_ack; k++) begin
            @(negedge clk);
            #1;
        end
        bus.j = 1'b1;
        bus.ta = 8'h20;
        @(negedge clk);
        #1;
        bus.j = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== 8'h20) begin
            failures++;
            $display("FAIL ack_flush valid=%b req=%b addr=%h required valid=0 req=1 addr=20",
                     bus.out_valid, bus.im_req, bus.im_addr);
        end
        wait_valid("ack_flush");
        checks++;
        if (bus.address !== 8'h20 || bus.instruction !== instr_of(8'h20)) begin
            failures++;
            $display("FAIL ack_flush_target address=%h instr=%h required address=20 instr=%h",
                     bus.address, bus.instruction, instr_of(8'h20));
        end
    endtask
    task automatic test_wrap();
        logic [7:0] exp_addr [4];
        exp_addr = '{8'hF8, 8'hFC, 8'h00, 8'h04};
        do_reset(1);
        for (int k = 0; k < 10 && !bus.im_req; k++) begin
            @(negedge clk);
            #1;
        end
        bus.j = 1'b1;
        bus.ta = 8'hF8;
        @(negedge clk);
        #1;
        bus.j = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        bus.le = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.address !== exp_addr[i] || bus.instruction !== instr_of(exp_addr[i])) begin
                failures++;
                $display("FAIL wrap[%0d] valid=%b address=%h instr=%h required valid=1 address=%h instr=%h",
                         i, bus.out_valid, bus.address, bus.instruction, exp_addr[i], instr_of(exp_addr[i]));
            end
            @(negedge clk);
            #1;
        end
    endtask
    task automatic test_async_reset();
        do_reset(3);
        wait_valid("pre_reset");
        checks++;
        if (bus.im_req !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_req req=%b required=1", bus.im_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.im_req, bus.im_addr, bus.out_valid, bus.address, bus.instruction} !== 50'h0) begin
            failures++;
            $display("FAIL async_reset req=%b addr=%h valid=%b address=%h instr=%h required all zero",
                     bus.im_req, bus.im_addr, bus.out_valid, bus.address, bus.instruction);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("restart");
        checks++;
        if (bus.address !== 8'h00 || bus.instruction !== instr_of(8'h00)) begin
            failures++;
            $display("FAIL restart address=%h instr=%h required address=00 instr=%h",
                     bus.address, bus.instruction, instr_of(8'h00));
        end
    endtask
    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush_drop();
        test_flush_ack();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
